// File: rtl/clk_div_bank.sv
// clk_div_bank: programmable multi-channel clock divider.
// Each of NCH channels counts 0..D-1 with a runtime-writable divisor D and
// drives a registered near-50% duty divided output plus a one-cycle tick in
// the last cycle of every period. New divisors are staged in a per-channel
// pending register and take effect on a period boundary, so no period is
// ever truncated while running.
// Optional feature macro: CLKDIV_SYNC_CLR_EN adds a sync_clr input that
// realigns every running channel to the start of a period.
module clk_div_bank #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
`ifdef CLKDIV_SYNC_CLR_EN
    input  logic                                   sync_clr,
`endif
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DW-1:0]                          cfg_div,
    output logic [NCH-1:0]                         div_out,
    output logic [NCH-1:0]                         tick
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // Divisors below 2 cannot form a high and a low phase, so they become 2.
    function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
        return (d < DW'(2)) ? DW'(2) : d;
    endfunction

    // High-phase length ceil(D/2); odd divisors spend the extra cycle high.
    function automatic logic [DW-1:0] half_div(input logic [DW-1:0] d);
        return (d >> 1) + {{(DW-1){1'b0}}, d[0]};
    endfunction

    // Power-up divisor of channel k: 2^(k+1), the legacy /2,/4,/8,/16 ladder.
    function automatic logic [DW-1:0] ladder_div(input int k);
        return DW'(1) << (k + 1);
    endfunction

    logic clr;
`ifdef CLKDIV_SYNC_CLR_EN
    assign clr = sync_clr;
`else
    assign clr = 1'b0;
`endif

    logic [DW-1:0]  act_div  [NCH];
    logic [DW-1:0]  pend_div [NCH];
    logic [DW-1:0]  cnt      [NCH];
    logic [DW-1:0]  act_nxt  [NCH];
    logic [DW-1:0]  cnt_nxt  [NCH];
    logic [NCH-1:0] pend;
    logic [NCH-1:0] pend_nxt;
    logic [NCH-1:0] ch_hit;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] apply;
    logic [NCH-1:0] div_nxt;
    logic [NCH-1:0] tick_nxt;

    // Decode the target channel; a channel with a staged divisor back-pressures
    // further writes, while out-of-range channel numbers are accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        ch_hit    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (NCH == 1 || cfg_ch == CHW'(k)) begin
                ch_hit[k] = 1'b1;
                cfg_ready = ~pend[k];
            end
        end
    end

    assign wr_en = ch_hit & {NCH{cfg_valid & cfg_ready}};

    // Per-channel next state: divisor swap at boundaries, counter advance or
    // park, and the output values that the new counter state implies.
    always_comb begin
        wrap     = '0;
        apply    = '0;
        div_nxt  = '0;
        tick_nxt = '0;
        pend_nxt = '0;
        for (int k = 0; k < NCH; k++) begin
            act_nxt[k] = act_div[k];
            cnt_nxt[k] = cnt[k];
        end
        for (int k = 0; k < NCH; k++) begin
            // A parked counter sits at D-1, so the first enabled edge wraps to 0.
            wrap[k]    = (cnt[k] == act_div[k] - DW'(1));
            apply[k]   = pend[k] & (~en | clr | wrap[k]);
            act_nxt[k] = apply[k] ? pend_div[k] : act_div[k];
            if (!en) begin
                cnt_nxt[k] = act_nxt[k] - DW'(1);
            end else if (clr || wrap[k]) begin
                cnt_nxt[k] = '0;
            end else begin
                cnt_nxt[k] = cnt[k] + DW'(1);
            end
            div_nxt[k]  = en & (cnt_nxt[k] < half_div(act_nxt[k]));
            tick_nxt[k] = en & (cnt_nxt[k] == act_nxt[k] - DW'(1));
            // An accept can only land on a channel with nothing staged.
            pend_nxt[k] = (pend[k] & ~apply[k]) | wr_en[k];
        end
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                act_div[k] <= ladder_div(k);
                cnt[k]     <= ladder_div(k) - DW'(1);
            end
            pend    <= '0;
            div_out <= '0;
            tick    <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                act_div[k] <= act_nxt[k];
                cnt[k]     <= cnt_nxt[k];
            end
            pend    <= pend_nxt;
            div_out <= div_nxt;
            tick    <= tick_nxt;
        end
    end

    // Staged divisor values; only read while the matching pend bit is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (wr_en[k]) begin
                pend_div[k] <= clamp_div(cfg_div);
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed bench for clk_div_bank with a time-based
// reference model (period start time + divisor per channel) compared every
// cycle, plus hand-computed literal expectations.
module tb_clk_div_bank;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] tick;
`ifdef CLKDIV_SYNC_CLR_EN
    logic           sync_clr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_bank #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
`ifdef CLKDIV_SYNC_CLR_EN
        .sync_clr  (sync_clr),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .div_out   (div_out),
        .tick      (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each channel remembers when its current period began
    // and its divisor; outputs follow from elapsed time within the period.
    int             m_t;
    int             m_st [NCH];
    int             m_dv [NCH];
    int             m_pd [NCH];
    bit             m_pf [NCH];
    bit             m_run;
    logic [NCH-1:0] m_div;
    logic [NCH-1:0] m_tick;

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_dv[k] = 2 << k;
            m_st[k] = 0;
            m_pd[k] = 2;
            m_pf[k] = 1'b0;
        end
        m_t    = 0;
        m_run  = 1'b0;
        m_div  = '0;
        m_tick = '0;
    endfunction

    initial begin
        bit r_rst, r_en, r_vld, r_clr, r_rdy, acc;
        int r_ch, r_div, e;
        model_reset();
        forever begin
            @(negedge clk);
            #4;
            r_rst = rst_n;
            r_en  = en;
            r_vld = cfg_valid;
            r_ch  = int'(cfg_ch);
            r_div = int'(cfg_div);
`ifdef CLKDIV_SYNC_CLR_EN
            r_clr = sync_clr;
`else
            r_clr = 1'b0;
`endif
            r_rdy = 1'b1;
            if (r_ch < NCH) r_rdy = !m_pf[r_ch];
            if (r_rst) chk("cfg_ready", 64'(cfg_ready), 64'(r_rdy));
            @(posedge clk);
            #1;
            if (!r_rst || !rst_n) begin
                model_reset();
            end else begin
                m_t++;
                acc = r_vld && r_rdy && (r_ch < NCH);
                if (!r_en) begin
                    m_run = 1'b0;
                    for (int k = 0; k < NCH; k++) begin
                        if (m_pf[k]) begin
                            m_dv[k] = m_pd[k];
                            m_pf[k] = 1'b0;
                        end
                    end
                end else begin
                    for (int k = 0; k < NCH; k++) begin
                        if (!m_run || r_clr || (m_t - 1 - m_st[k]) == m_dv[k] - 1) begin
                            if (m_pf[k]) begin
                                m_dv[k] = m_pd[k];
                                m_pf[k] = 1'b0;
                            end
                            m_st[k] = m_t;
                        end
                    end
                    m_run = 1'b1;
                end
                if (acc) begin
                    m_pf[r_ch] = 1'b1;
                    m_pd[r_ch] = (r_div < 2) ? 2 : r_div;
                end
                for (int k = 0; k < NCH; k++) begin
                    e         = m_t - m_st[k];
                    m_div[k]  = m_run && (e < (m_dv[k] + 1) / 2);
                    m_tick[k] = m_run && (e == m_dv[k] - 1);
                end
            end
            chk("div_out", 64'(div_out), 64'(m_div));
            chk("tick", 64'(tick), 64'(m_tick));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
`ifdef CLKDIV_SYNC_CLR_EN
        sync_clr  = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_div", 64'(div_out), 64'(0));
        chk("reset_tick", 64'(tick), 64'(0));
        chk("reset_ready", 64'(cfg_ready), 64'(1));
        rst_n = 1'b1;
    endtask

    // Called at a negedge with en just raised: the legacy ladder after edges 1..4.
    task automatic check_ladder();
        logic [3:0] ed [4];
        logic [3:0] et [4];
        ed = '{4'b1111, 4'b1110, 4'b1101, 4'b1100};
        et = '{4'b0000, 4'b0001, 4'b0000, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ladder_div", 64'(div_out), 64'(ed[i]));
            chk("ladder_tick", 64'(tick), 64'(et[i]));
        end
    endtask

    task automatic cfg_write(input int ch, input int d, output int stalls);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = DW'(d);
        stalls    = 0;
        #1;
        while (!cfg_ready && stalls < 200) begin
            @(negedge clk);
            stalls++;
            #1;
        end
        if (!cfg_ready) chk("write_timeout", 64'(stalls), 64'(0));
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int          st, cnt2, cnt3, hi2, acc_e;
        bit          waiting, clr_nxt;
        logic [11:0] s_div, s_tick;
        logic [63:0] tmask;
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
`ifdef CLKDIV_SYNC_CLR_EN
        sync_clr  = 1'b0;
`endif

        // Power-up ladder and tick rates
        do_reset();
        en = 1'b1;
        check_ladder();
        cnt2 = 0;
        cnt3 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cnt2 += int'(tick[2]);
            cnt3 += int'(tick[3]);
        end
        chk("ch2_ticks_32", 64'(cnt2), 64'(4));
        chk("ch3_ticks_32", 64'(cnt3), 64'(2));

        // ch1 4 -> 5 written while cnt=1
        do_reset();
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 8'd5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) cfg_valid = 1'b0;
            s_div[i]  = div_out[1];
            s_tick[i] = tick[1];
        end
        chk("ch1_d5_div_seq", 64'(s_div), 64'(12'b001110011100));
        chk("ch1_d5_tick_seq", 64'(s_tick), 64'(12'b100001000010));

        // Divisors 0 and 1 clamp to 2
        cfg_write(2, 0, st);
        cfg_write(2, 1, st);
        repeat (12) @(negedge clk);
        cnt2 = 0;
        hi2  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt2 += int'(tick[2]);
            hi2  += int'(div_out[2]);
        end
        chk("ch2_clamp_ticks", 64'(cnt2), 64'(5));
        chk("ch2_clamp_high", 64'(hi2), 64'(5));

        // Back-to-back ch3 writes with a ch0 write in between
        do_reset();
        en      = 1'b1;
        acc_e   = 0;
        waiting = 1'b0;
        clr_nxt = 1'b0;
        tmask   = '0;
        for (int e = 1; e <= 50; e++) begin
            @(negedge clk);
            if (tick[3]) tmask[e] = 1'b1;
            if (clr_nxt) begin
                cfg_valid = 1'b0;
                clr_nxt   = 1'b0;
            end
            case (e)
                1: begin
                    cfg_valid = 1'b1;
                    cfg_ch    = 2'd3;
                    cfg_div   = 8'd20;
                    #1;
                    chk("ch3_first_ready", 64'(cfg_ready), 64'(1));
                end
                2: begin
                    cfg_div = 8'd6;
                    #1;
                    chk("ch3_stall", 64'(cfg_ready), 64'(0));
                end
                3: begin
                    cfg_ch  = 2'd0;
                    cfg_div = 8'd3;
                    #1;
                    chk("ch0_no_stall", 64'(cfg_ready), 64'(1));
                end
                4: begin
                    cfg_ch  = 2'd3;
                    cfg_div = 8'd6;
                    waiting = 1'b1;
                end
                default: ;
            endcase
            if (waiting) begin
                #1;
                if (cfg_ready) begin
                    acc_e   = e + 1;
                    waiting = 1'b0;
                    clr_nxt = 1'b1;
                end
            end
        end
        chk("ch3_second_accept_edge", 64'(acc_e), 64'(18));
        chk("ch3_tick_edges", tmask,
            (64'(1) << 16) | (64'(1) << 36) | (64'(1) << 42) | (64'(1) << 48));

        // Enable drop, re-raise, asynchronous reset
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_div", 64'(div_out), 64'(0));
        chk("en_off_tick", 64'(tick), 64'(0));
        en = 1'b1;
        @(negedge clk);
        chk("realign_div", 64'(div_out), 64'(4'b1111));
        chk("realign_tick", 64'(tick), 64'(0));
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_div", 64'(div_out), 64'(0));
        chk("async_rst_tick", 64'(tick), 64'(0));
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        check_ladder();

`ifdef CLKDIV_SYNC_CLR_EN
        // Synchronous realignment of free-running channels
        do_reset();
        en = 1'b1;
        cfg_write(1, 3, st);
        cfg_write(2, 7, st);
        repeat (20) @(negedge clk);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        chk("clr_div12", 64'(div_out[2:1]), 64'(2'b11));
        chk("clr_tick", 64'(tick), 64'(0));
        s_div  = '0;
        s_tick = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            s_div[i]  = tick[1];
            s_tick[i] = tick[2];
        end
        chk("clr_ch1_ticks", 64'(s_div), 64'(12'b000100100100));
        chk("clr_ch2_ticks", 64'(s_tick), 64'(12'b000001000000));
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
